// File: rtl/div_clk_monitor_pkg.sv
// Shared definitions for the divided-clock monitor: FSM encoding, default
// parameter values and the period tolerance helper.
package div_clk_monitor_pkg;

  localparam int unsigned DIV_DEF      = 31;
  localparam int unsigned TOL_DEF      = 0;
  localparam int unsigned LOCK_CNT_DEF = 4;
  localparam int unsigned CW_DEF       = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2,
    LOCKED    = 2'd3
  } state_e;

  // True when a measured interval lies within +/-tol of the target.
  function automatic logic within_tol(input int unsigned meas,
                                      input int unsigned target,
                                      input int unsigned tol);
    int unsigned diff;
    diff = (meas >= target) ? (meas - target) : (target - meas);
    return (diff <= tol);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous divided clock into the clk
// domain; both stages clear on reset so no stale edge survives a reset.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/div_clk_monitor.sv
// Measures period and high phase of a divided clock, declares lock after a run
// of in-tolerance periods and raises a sticky error on drift or a stalled input.
module div_clk_monitor
  import div_clk_monitor_pkg::*;
#(
  parameter int unsigned DIV      = DIV_DEF,
  parameter int unsigned TOL      = TOL_DEF,
  parameter int unsigned LOCK_CNT = LOCK_CNT_DEF,
  parameter int unsigned CW       = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          din,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic          meas_valid,
  output logic          locked,
  output logic          err
);

  localparam int unsigned   GW       = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_TO   = CNT_MAX - CW'(1);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_CNT);

  state_e        state_q, state_d;
  logic          din_s;
  logic          din_d_q;
  logic          rise_c;
  logic          fall_c;
  logic          period_good_c;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] hi_q, hi_d;
  logic [GW-1:0] good_q, good_d;
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] high_q, high_d;
  logic          mv_q, mv_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (din),
    .q     (din_s)
  );

  // Edge detection against the registered copy of the synchronized input.
  assign rise_c        = din_s & ~din_d_q;
  assign fall_c        = ~din_s & din_d_q;
  assign period_good_c = within_tol(32'(cnt_q), DIV, TOL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      din_d_q  <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      good_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      mv_q     <= 1'b0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      din_d_q  <= din_s;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      good_q   <= good_d;
      period_q <= period_d;
      high_q   <= high_d;
      mv_q     <= mv_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    good_d   = good_q;
    period_d = period_q;
    high_d   = high_q;
    mv_d     = 1'b0;
    locked_d = locked_q;
    err_d    = err_q;

    // Interval counter restarts at 1 on each rise and saturates instead of wrapping.
    if (rise_c) begin
      cnt_d = CW'(1);
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end

    if (rise_c) begin
      hi_d = CW'(1);
    end else if (fall_c) begin
      hi_d = hi_q;
    end else if (din_s && (hi_q != CNT_MAX)) begin
      hi_d = hi_q + CW'(1);
    end

    unique case (state_q)
      IDLE: begin
        cnt_d    = '0;
        hi_d     = '0;
        good_d   = '0;
        locked_d = 1'b0;
        err_d    = 1'b0;
        state_d  = WAIT_EDGE;
      end

      WAIT_EDGE: begin
        if (rise_c) begin
          state_d = MEASURE;
        end
      end

      MEASURE, LOCKED: begin
        if (rise_c) begin
          period_d = cnt_q;
          high_d   = hi_q;
          mv_d     = 1'b1;
          if (period_good_c) begin
            good_d = (good_q == GOOD_MAX) ? good_q : (good_q + GW'(1));
            if (good_d == GOOD_MAX) begin
              locked_d = 1'b1;
              state_d  = LOCKED;
            end
          end else begin
            good_d = '0;
            if (state_q == LOCKED) begin
              err_d    = 1'b1;
              locked_d = 1'b0;
              state_d  = MEASURE;
            end
          end
        end else if (cnt_q == CNT_TO) begin
          // Counter is about to hit its ceiling with no edge: input has stalled.
          err_d    = 1'b1;
          locked_d = 1'b0;
          good_d   = '0;
          state_d  = WAIT_EDGE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Disable overrides any edge or timeout seen in the same cycle.
    if (!en) begin
      state_d  = IDLE;
      cnt_d    = '0;
      hi_d     = '0;
      good_d   = '0;
      period_d = period_q;
      high_d   = high_q;
      mv_d     = 1'b0;
      locked_d = 1'b0;
      err_d    = 1'b0;
    end
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = mv_q;
  assign locked     = locked_q;
  assign err        = err_q;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Table-driven bench for div_clk_monitor: each row drives one din period,
// optionally preceded by a control event, and queues the measurement it should yield.
module tb_div_clk_monitor;
  import div_clk_monitor_pkg::*;

  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          din;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          meas_valid;
  logic          locked;
  logic          err;

  always #5 clk = ~clk;

  div_clk_monitor #(
    .DIV      (31),
    .TOL      (0),
    .LOCK_CNT (4),
    .CW       (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .din        (din),
    .period     (period),
    .high_time  (high_time),
    .meas_valid (meas_valid),
    .locked     (locked),
    .err        (err)
  );

  typedef enum int {A_NONE, A_ENDROP, A_RESET, A_TIMEOUT, A_ENLOW} act_e;

  typedef struct {
    act_e        act;
    int unsigned per;
    int unsigned hi;
    bit          meas;
    int unsigned e_per;
    int unsigned e_hi;
    bit          e_lock;
    bit          e_err;
  } vec_t;

  typedef struct {
    int unsigned per;
    int unsigned hi;
    bit          lock;
    bit          err;
    int          idx;
    int unsigned gap;
  } exp_t;

  localparam int NV = 33;

  vec_t tbl [NV];
  exp_t sb_q [$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  int   last_mv_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input act_e a, input int unsigned per, input int unsigned hi,
                              input bit meas, input int unsigned ep, input int unsigned eh,
                              input bit el, input bit ee);
    vec_t v;
    v.act = a; v.per = per; v.hi = hi; v.meas = meas;
    v.e_per = ep; v.e_hi = eh; v.e_lock = el; v.e_err = ee;
    return v;
  endfunction

  // Scoreboard consumer: every meas_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset && meas_valid) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_meas_valid: got period %0d, required no pulse (t=%0t)", period, $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check($sformatf("period[%0d]", e.idx), 32'(period), 32'(e.per));
        check($sformatf("high_time[%0d]", e.idx), 32'(high_time), 32'(e.hi));
        check($sformatf("locked[%0d]", e.idx), 32'(locked), 32'(e.lock));
        check($sformatf("err[%0d]", e.idx), 32'(err), 32'(e.err));
        if (e.gap != 0) check($sformatf("mv_gap[%0d]", e.idx), 32'(cyc - last_mv_cyc), 32'(e.gap));
      end
      last_mv_cyc = cyc;
    end
  end

  task automatic pre_action(input act_e a);
    bit got;
    case (a)
      A_ENDROP: begin
        en = 1'b0;
        @(posedge clk); #1;
        en = 1'b1;
        check("endrop_locked", 32'(locked), 32'd0);
        check("endrop_err", 32'(err), 32'd0);
        check("endrop_state", 32'(dut.state_q), 32'(IDLE));
      end
      A_RESET: begin
        reset = 1'b0;
        #1;
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_period", 32'(period), 32'd0);
        check("rst_high_time", 32'(high_time), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
      end
      A_TIMEOUT: begin
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
          @(negedge clk);
          if (err) got = 1'b1;
        end
        check("timeout_err", 32'(err), 32'd1);
        check("timeout_gap", 32'(cyc - last_mv_cyc), 32'd254);
        check("timeout_locked", 32'(locked), 32'd0);
        check("timeout_state", 32'(dut.state_q), 32'(WAIT_EDGE));
        check("timeout_cnt", 32'(dut.cnt_q), 32'd255);
        repeat (30) @(negedge clk);
        check("nowrap_cnt", 32'(dut.cnt_q), 32'd255);
        check("nowrap_state", 32'(dut.state_q), 32'(WAIT_EDGE));
        @(posedge clk); #1;
      end
      default: ;
    endcase
  endtask

  task automatic drive_entry(input vec_t v, input int idx, input int unsigned gap);
    pre_action(v.act);
    if (v.meas) sb_q.push_back('{per: v.e_per, hi: v.e_hi, lock: v.e_lock, err: v.e_err, idx: idx, gap: gap});
    for (int c = 0; c < int'(v.per); c++) begin
      din = (c < int'(v.hi));
      if (v.act == A_ENLOW) begin
        if (c == 2) en = 1'b0;
        if (c == 3) begin
          check("enlow_state", 32'(dut.state_q), 32'(IDLE));
          check("enlow_mv", 32'(meas_valid), 32'd0);
          check("enlow_locked", 32'(locked), 32'd0);
          en = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned gap;
    tbl[0]  = mk(A_NONE,    31, 15, 0,  0,  0, 0, 0);
    tbl[1]  = mk(A_NONE,    31, 15, 1, 31, 15, 0, 0);
    tbl[2]  = mk(A_NONE,    31, 15, 1, 31, 15, 0, 0);
    tbl[3]  = mk(A_NONE,    31, 15, 1, 31, 15, 0, 0);
    tbl[4]  = mk(A_NONE,    31, 15, 1, 31, 15, 1, 0);
    tbl[5]  = mk(A_NONE,    30, 15, 1, 31, 15, 1, 0);
    tbl[6]  = mk(A_NONE,    31, 15, 1, 30, 15, 0, 1);
    tbl[7]  = mk(A_NONE,    31, 15, 1, 31, 15, 0, 1);
    tbl[8]  = mk(A_NONE,    31, 15, 1, 31, 15, 0, 1);
    tbl[9]  = mk(A_NONE,    31, 15, 1, 31, 15, 0, 1);
    tbl[10] = mk(A_NONE,    31, 15, 1, 31, 15, 1, 1);
    tbl[11] = mk(A_ENDROP,  30, 15, 0,  0,  0, 0, 0);
    tbl[12] = mk(A_NONE,    30, 15, 1, 30, 15, 0, 0);
    tbl[13] = mk(A_NONE,    30, 15, 1, 30, 15, 0, 0);
    tbl[14] = mk(A_NONE,    31, 15, 1, 30, 15, 0, 0);
    tbl[15] = mk(A_NONE,    31, 15, 1, 31, 15, 0, 0);
    tbl[16] = mk(A_NONE,    31, 15, 1, 31, 15, 0, 0);
    tbl[17] = mk(A_NONE,    31, 15, 1, 31, 15, 0, 0);
    tbl[18] = mk(A_NONE,    31, 15, 1, 31, 15, 1, 0);
    tbl[19] = mk(A_RESET,   31, 12, 0,  0,  0, 0, 0);
    tbl[20] = mk(A_NONE,    31, 12, 1, 31, 12, 0, 0);
    tbl[21] = mk(A_NONE,    31, 12, 1, 31, 12, 0, 0);
    tbl[22] = mk(A_NONE,    31, 12, 1, 31, 12, 0, 0);
    tbl[23] = mk(A_NONE,    31, 12, 1, 31, 12, 1, 0);
    tbl[24] = mk(A_TIMEOUT, 31, 15, 0,  0,  0, 0, 0);
    tbl[25] = mk(A_NONE,    31, 15, 1, 31, 15, 0, 1);
    tbl[26] = mk(A_NONE,    31, 15, 1, 31, 15, 0, 1);
    tbl[27] = mk(A_NONE,    31, 15, 1, 31, 15, 0, 1);
    tbl[28] = mk(A_NONE,    31, 15, 1, 31, 15, 1, 1);
    tbl[29] = mk(A_ENLOW,   31, 15, 0,  0,  0, 0, 0);
    tbl[30] = mk(A_NONE,    31, 15, 0,  0,  0, 0, 0);
    tbl[31] = mk(A_NONE,    31, 15, 1, 31, 15, 0, 0);
    tbl[32] = mk(A_NONE,    31, 15, 1, 31, 15, 0, 0);

    reset = 1'b0;
    en    = 1'b0;
    din   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_period", 32'(period), 32'd0);
    check("reset_high_time", 32'(high_time), 32'd0);
    check("reset_meas_valid", 32'(meas_valid), 32'd0);
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b1;
    en    = 1'b1;

    for (int i = 0; i < NV; i++) begin
      gap = 0;
      if (i > 0 && tbl[i].act == A_NONE && tbl[i].meas && tbl[i-1].meas) gap = tbl[i].e_per;
      drive_entry(tbl[i], i, gap);
    end

    din = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
